// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX register with load-use stall, branch flush sequencing, memory-busy freeze and saturating bubble counter
module id_ex_hazard_stage #(
  parameter int REG_W  = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rs_en,
  input  logic              id_rt_en,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              ex_flush,
  input  logic              mem_busy,
  output logic              stall_if,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_rs_en,
  output logic              ex_rt_en,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [CNT_W-1:0]  bubble_cnt
);
  localparam int W = 5 + 3*REG_W + 2*DATA_W;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t           r_state;
  logic [W-1:0]     r_ex;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lu;
  logic             w_bubble;
  assign w_lu = ex_valid & ex_mem_read & ex_reg_write & id_valid &
                ((id_rs_en & (id_rs == ex_rd)) | (id_rt_en & (id_rt == ex_rd)));
  assign w_bubble = ex_flush | (r_state == FLUSH) | w_lu;
  assign stall_if = mem_busy | (w_lu & ~ex_flush & (r_state == RUN));
  assign {ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_en, ex_rt_en, ex_reg_write, ex_mem_read,
          ex_rs_data, ex_rt_data} = r_ex;
  assign bubble_cnt = r_cnt;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= RUN;
      r_ex    <= '0;
      r_cnt   <= '0;
    end else if (!mem_busy) begin
      r_state <= ex_flush ? FLUSH : RUN;
      r_ex    <= w_bubble ? '0 : {id_valid, id_rs, id_rt, id_rd, id_rs_en, id_rt_en,
                                  id_reg_write, id_mem_read, id_rs_data, id_rt_data};
      r_cnt   <= r_cnt + CNT_W'(w_bubble && (r_cnt != '1));
    end
endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

ID/EX pipeline register with integrated load-use hazard detection, branch flush sequencing and memory-busy freeze. It sits directly upstream of the forwarding unit and drives its `ex_rs`, `ex_rt`, `ex_rs_en` and `ex_rt_en` inputs. It also supplies the EX stage with operands and control. It inserts bubbles and raises `stall_if` so that the forwarding unit only ever sees hazards it can resolve from MEM or WB.

## Interface
- `REG_W`, default 2: register address width (4 architectural registers).
- `DATA_W`, default 8: operand data width.
- `CNT_W`, default 8: width of the bubble performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  `REG_W`  source register addresses.
- `id_rs_en`, `id_rt_en`  in  1  instruction actually reads rs / rt.
- `id_rd`  in  `REG_W`  destination register address.
- `id_reg_write`, `id_mem_read`  in  1  writes a register / is a load.
- `id_rs_data`, `id_rt_data`  in  `DATA_W`  register-file read data.
- `ex_flush`  in  1  taken branch resolved in EX this cycle.
- `mem_busy`  in  1  data memory not ready; the whole pipe freezes.
- `stall_if`  out  1  hold PC and IF/ID this cycle (combinational).
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_rs`, `ex_rt`, `ex_rd`  out  `REG_W`  registered addresses.
- `ex_rs_en`, `ex_rt_en`, `ex_reg_write`, `ex_mem_read`  out  1  registered control.
- `ex_rs_data`, `ex_rt_data`  out  `DATA_W`  registered operands.
- `bubble_cnt`  out  `CNT_W`  saturating count of inserted bubbles.

## Operation
- **Bubble** means the following is loaded into ID/EX: `ex_valid`, `ex_rs_en`, `ex_rt_en`, `ex_reg_write` and `ex_mem_read` all 0. All address and data fields are 0.
- **Load-use hazard (`lu`)**, combinational:
  - Condition: `ex_valid & ex_mem_read & ex_reg_write & id_valid`, AND either `(id_rs_en & id_rs==ex_rd)` or `(id_rt_en & id_rt==ex_rd)`.
  - `rd==0` is not special-cased.
- **State machine** states are RUN and FLUSH.
  - RUN: ID is accepted normally.
  - FLUSH: the ID instruction present is wrong-path and is discarded.
- **Per-cycle priority** (highest first):
  1. `rst`: ID/EX is loaded with a bubble, state goes to RUN, `bubble_cnt` is cleared to 0.
  2. `mem_busy=1`: all registers, state and counter hold. `stall_if=1`. `ex_flush` is ignored; upstream keeps it asserted until `mem_busy` drops.
  3. `ex_flush=1`: a bubble is loaded, state goes to FLUSH, `bubble_cnt` increments. `lu` is ignored.
  4. State FLUSH: a bubble is loaded, state goes to RUN, `bubble_cnt` increments. `lu` is ignored.
  5. `lu=1`: a bubble is loaded, `stall_if=1`, `bubble_cnt` increments. The ID instruction is retained upstream and re-presented next cycle.
  6. Otherwise all `id_*` fields are captured into `ex_*`, with `ex_valid=id_valid`.
- `stall_if = mem_busy | (lu & ~ex_flush & state==RUN)`. No other source asserts it.
- `bubble_cnt` saturates at 2^`CNT_W`−1 and never wraps.
- Cases where `id_valid=0` is captured in step 6 are not counted as bubbles.

## Timing
- Reset values: all `ex_*` outputs are 0, `bubble_cnt=0`, state is RUN. `stall_if` equals `mem_busy` during reset.
- ID to EX latency is 1 cycle.
- A load-use pair costs exactly 1 bubble. The dependent instruction enters EX two cycles after the load and therefore forwards from WB.
- A taken branch costs exactly 2 bubbles: the cycle with `ex_flush` plus the FLUSH cycle.
- `ex_flush` arriving while in FLUSH state restarts FLUSH, giving 2 more bubbles from that cycle.
- `mem_busy` asserted while in FLUSH holds FLUSH. The remaining bubble is inserted after `mem_busy` drops.
- A `rst` asserted mid-stall or mid-flush takes effect at the next edge with no residual state.
- `stall_if` is combinational from current registers and inputs and is valid in the same cycle.

## Test plan
- **Reset:** hold `rst` 2 cycles with random `id_*` -> all `ex_*`=0, `bubble_cnt`=0. With `mem_busy=0`, `stall_if`=0.
- **Normal capture:** `id_rs=1`, `id_rt=2`, `id_rd=3`, data `0x5A`/`0xC3`, `reg_write=1` -> next cycle `ex_*` match exactly, `stall_if`=0.
- **Load-use:** load with `rd=1` in EX, then ID with `rs=1`, `rs_en=1` -> `stall_if`=1 for 1 cycle, 1 bubble in EX, dependent instruction in EX one cycle later, `bubble_cnt`=1. Repeat with `rs_en=0` -> no stall.
- **Branch flush:** `ex_flush` pulse for 1 cycle -> 2 consecutive bubbles, `bubble_cnt`+2. An `lu` condition present during FLUSH is ignored and `stall_if`=0.
- **Freeze:** `mem_busy=1` for 3 cycles while in FLUSH -> `ex_*` and counter hold, `stall_if`=1. After release, 1 bubble, then normal capture.
- **Saturation:** with `CNT_W=2`, force 5 load-use stalls -> `bubble_cnt` stops at 3.
